md_unit: RTL and testbench
==========================

MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy cycles for mult-class ops.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy cycles for div-class ops.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  E-stage strobe; the op on mdop is issued this cycle.
REQ-006 SHALL have port mdop  input  4  operation code (shared package encoding).
REQ-007 SHALL have port A  input  32  forwarded rs value from the D/E register.
REQ-008 SHALL have port B  input  32  forwarded rt value from the D/E register.
REQ-009 SHALL have port busy  output  1  registered; high while a mult/div is in flight.
REQ-010 SHALL have port HI  output  32  current HI register.
REQ-011 SHALL have port LO  output  32  current LO register.

Function
REQ-012 SHALL have exactly two states: IDLE and BUSY.
REQ-013 SHALL, in IDLE on start with MULT/MULTU/DIV/DIVU, latch A, B and mdop, load the counter, enter BUSY next edge.
REQ-014 SHALL hold busy high for exactly MULT_CYCLES (mult) or DIV_CYCLES (div) cycles, starting the cycle after start.
REQ-015 SHALL update HI/LO on the edge that ends the last busy cycle, so new values and busy=0 appear together.
REQ-016 SHALL compute MULT as a 64-bit signed product and MULTU as unsigned: HI = upper 32 bits, LO = lower 32 bits.
REQ-017 SHALL compute DIV signed, truncating toward zero: LO = quotient, HI = remainder with the sign of the dividend.
REQ-018 SHALL compute DIVU unsigned: LO = quotient, HI = remainder.
REQ-019 SHALL leave HI/LO unchanged when the divisor is 0, while still taking DIV_CYCLES busy cycles.
REQ-020 SHALL give LO=0x80000000, HI=0 for DIV 0x80000000 / 0xFFFFFFFF.
REQ-021 SHALL, on start with MTHI or MTLO in IDLE, write A to HI or LO on that edge, with no busy.
REQ-022 SHALL ignore start while BUSY and SHALL ignore undefined mdop codes; the hazard unit stalls D instead.
REQ-023 SHALL take operands from the latched copies only; A/B changes during BUSY have no effect.

Reset
REQ-024 SHALL, on reset low at any time including mid-operation, force IDLE, counter=0, busy=0, HI=0, LO=0.
REQ-025 SHALL discard any in-flight result when reset is asserted.

Configuration
REQ-026 SHALL, when MD_UNIT_MADD_EN is defined, accept MADD/MADDU/MSUB/MSUBU: {HI,LO} +/- the product (signed/unsigned), MULT_CYCLES latency, modulo 2^64.
REQ-027 SHALL, when MD_UNIT_MADD_EN is undefined, treat those four codes as undefined per REQ-022.

Structure
REQ-028 SHALL place mdop encodings in shared package md_defs: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MADD=7, MADDU=8, MSUB=9, MSUBU=10.
REQ-029 SHALL place the default MULT_CYCLES/DIV_CYCLES values and the state encoding in the same package md_defs.
REQ-030 SHALL be one module with no sub-modules; result arithmetic is behavioural and the counter is internal.

Verification
REQ-031 SHALL cover: MULT A=0xFFFFFFFE (-2), B=3 -> busy for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-032 SHALL cover: DIVU A=7, B=2 -> busy for 10 cycles, then LO=3, HI=1; DIV A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-033 SHALL cover: MTHI A=0x12345678 -> HI=0x12345678 next cycle, busy never asserted.
REQ-034 SHALL cover: DIV with B=0 after HI=LO=5 -> busy for 10 cycles, HI=LO=5 retained.
REQ-035 SHALL cover: MULTU started, reset low at busy cycle 3 -> busy=0, HI=LO=0 immediately; start again during BUSY -> ignored, first result is unchanged.
REQ-036 SHALL cover, with MD_UNIT_MADD_EN defined: HI=0, LO=0xFFFFFFFF, then MADDU A=1, B=1 -> HI=1, LO=0 after 5 cycles.

Source files
------------

// File: rtl/md_defs.sv
// Shared definitions for the multiply/divide unit: mdop encodings, default latencies, state encoding.
// Op-class helpers honour MD_UNIT_MADD_EN (multiply-accumulate ops enabled when defined).
package md_defs;

   typedef enum logic [3:0] {
      MD_NONE  = 4'd0,
      MD_MULT  = 4'd1,
      MD_MULTU = 4'd2,
      MD_DIV   = 4'd3,
      MD_DIVU  = 4'd4,
      MD_MTHI  = 4'd5,
      MD_MTLO  = 4'd6,
      MD_MADD  = 4'd7,
      MD_MADDU = 4'd8,
      MD_MSUB  = 4'd9,
      MD_MSUBU = 4'd10
   } mdop_e;

   localparam int unsigned MULT_CYCLES_DEF = 5;
   localparam int unsigned DIV_CYCLES_DEF  = 10;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } md_state_e;

   function automatic logic is_mult_op(input logic [3:0] op);
      logic hit;
      hit = (op == MD_MULT) || (op == MD_MULTU);
`ifdef MD_UNIT_MADD_EN
      hit = hit || (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
`endif
      return hit;
   endfunction

   function automatic logic is_div_op(input logic [3:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/md_unit.sv
// Iterative-latency multiply/divide unit with HI/LO registers and a down-counter busy timer.
// Build option: define MD_UNIT_MADD_EN to enable MADD/MADDU/MSUB/MSUBU.
module md_unit
   import md_defs::*;
#(
   parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  mdop,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   // state  | meaning
   // IDLE   | accepts MT* immediately, or latches a mult/div op and loads the timer
   // BUSY   | timer counting down; HI/LO written as the last busy cycle ends

   localparam int unsigned CNT_MAX = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
   localparam int CNT_W = $clog2(CNT_MAX + 1);

   md_state_e         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic [31:0]       hi_q, hi_d, lo_q, lo_d;
   logic [31:0]       a_q, a_d, b_q, b_d;
   logic [3:0]        op_q, op_d;

   logic [63:0]        result;
   logic [63:0]        prod_u;
   logic signed [63:0] prod_s;
   logic [31:0]        b_safe;
   logic signed [32:0] dvd_s, dvs_s;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (start && (is_mult_op(mdop) || is_div_op(mdop))) state_d = S_BUSY;
         S_BUSY: if (cnt_q == CNT_W'(1)) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Divide by a non-zero stand-in when B is 0; the result is discarded in that case.
   always_comb begin
      b_safe = (b_q == 32'd0) ? 32'd1 : b_q;
      prod_u = {32'd0, a_q} * {32'd0, b_q};
      prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
      dvd_s  = $signed({a_q[31], a_q});
      dvs_s  = $signed({b_safe[31], b_safe});
      result = {hi_q, lo_q};
      case (op_q)
         MD_MULT:  result = prod_s;
         MD_MULTU: result = prod_u;
         MD_DIV:   if (b_q != 32'd0) result = {32'(dvd_s % dvs_s), 32'(dvd_s / dvs_s)};
         MD_DIVU:  if (b_q != 32'd0) result = {a_q % b_safe, a_q / b_safe};
`ifdef MD_UNIT_MADD_EN
         MD_MADD:  result = {hi_q, lo_q} + prod_s;
         MD_MADDU: result = {hi_q, lo_q} + prod_u;
         MD_MSUB:  result = {hi_q, lo_q} - prod_s;
         MD_MSUBU: result = {hi_q, lo_q} - prod_u;
`endif
         default:  result = {hi_q, lo_q};
      endcase
   end

   always_comb begin
      cnt_d  = cnt_q;
      hi_d   = hi_q;
      lo_d   = lo_q;
      a_d    = a_q;
      b_d    = b_q;
      op_d   = op_q;
      busy_d = (state_d == S_BUSY);
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (is_mult_op(mdop) || is_div_op(mdop)) begin
                  a_d   = A;
                  b_d   = B;
                  op_d  = mdop;
                  cnt_d = is_div_op(mdop) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
               end else if (mdop == MD_MTHI) begin
                  hi_d = A;
               end else if (mdop == MD_MTLO) begin
                  lo_d = A;
               end
            end
         end
         S_BUSY: begin
            if (cnt_q == CNT_W'(1)) begin
               cnt_d        = '0;
               {hi_d, lo_d} = result;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: cnt_d = '0;
      endcase
   end

   assign busy = busy_q;
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit; exercises the MADD path when MD_UNIT_MADD_EN is defined.
module tb_md_unit;
   import md_defs::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  mdop = 4'd0;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        busy;
   logic [31:0] HI, LO;

   int vecs = 0;
   int errs = 0;
   int n;

   md_unit dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .mdop  (mdop),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .HI    (HI),
      .LO    (LO)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1'b1;
      mdop  = op;
      A     = a;
      B     = b;
      @(negedge clk);
      start = 1'b0;
      mdop  = MD_NONE;
   endtask

   task automatic count_busy(output int cnt);
      cnt = 0;
      while (busy === 1'b1 && cnt < 64) begin
         cnt++;
         @(negedge clk);
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_hi", HI, 32'd0);
      chk("rst_lo", LO, 32'd0);
      reset = 1'b1;

      issue(MD_MULT, 32'hFFFF_FFFE, 32'd3);
      count_busy(n);
      chk("mult_cycles", n, 32'd5);
      chk("mult_hi", HI, 32'hFFFF_FFFF);
      chk("mult_lo", LO, 32'hFFFF_FFFA);

      issue(MD_DIVU, 32'd7, 32'd2);
      count_busy(n);
      chk("divu_cycles", n, 32'd10);
      chk("divu_lo", LO, 32'd3);
      chk("divu_hi", HI, 32'd1);

      issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
      count_busy(n);
      chk("div_cycles", n, 32'd10);
      chk("div_lo", LO, 32'hFFFF_FFFD);
      chk("div_hi", HI, 32'hFFFF_FFFF);

      issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      count_busy(n);
      chk("divovf_lo", LO, 32'h8000_0000);
      chk("divovf_hi", HI, 32'd0);

      issue(MD_MTHI, 32'h1234_5678, 32'd0);
      chk("mthi_hi", HI, 32'h1234_5678);
      chk("mthi_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      chk("mthi_busy2", {31'd0, busy}, 32'd0);

      issue(MD_MTHI, 32'd5, 32'd0);
      issue(MD_MTLO, 32'd5, 32'd0);
      issue(MD_DIV, 32'd99, 32'd0);
      count_busy(n);
      chk("div0_cycles", n, 32'd10);
      chk("div0_hi", HI, 32'd5);
      chk("div0_lo", LO, 32'd5);

      // second start during BUSY plus operand churn must not disturb the first op
      issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      n = 0;
      while (busy === 1'b1 && n < 64) begin
         n++;
         if (n == 2) begin
            start = 1'b1;
            mdop  = MD_DIVU;
            A     = 32'd7;
            B     = 32'd2;
         end else begin
            start = 1'b0;
            mdop  = MD_NONE;
            A     = $urandom;
            B     = $urandom;
         end
         @(negedge clk);
      end
      start = 1'b0;
      chk("ign_cycles", n, 32'd5);
      chk("ign_hi", HI, 32'hFFFF_FFFE);
      chk("ign_lo", LO, 32'h0000_0001);
      @(negedge clk);
      chk("ign_busy_after", {31'd0, busy}, 32'd0);

      issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
      repeat (2) @(negedge clk);
      chk("mid_busy_before", {31'd0, busy}, 32'd1);
      reset = 1'b0;
      #1;
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_hi", HI, 32'd0);
      chk("mid_rst_lo", LO, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (8) @(negedge clk);
      chk("post_rst_busy", {31'd0, busy}, 32'd0);
      chk("post_rst_hi", HI, 32'd0);
      chk("post_rst_lo", LO, 32'd0);

      issue(MD_MTHI, 32'hA5A5_A5A5, 32'd0);
      issue(4'd11, 32'd3, 32'd3);
      chk("undef_busy", {31'd0, busy}, 32'd0);
      chk("undef_hi", HI, 32'hA5A5_A5A5);

`ifdef MD_UNIT_MADD_EN
      issue(MD_MTHI, 32'd0, 32'd0);
      issue(MD_MTLO, 32'hFFFF_FFFF, 32'd0);
      issue(MD_MADDU, 32'd1, 32'd1);
      count_busy(n);
      chk("maddu_cycles", n, 32'd5);
      chk("maddu_hi", HI, 32'd1);
      chk("maddu_lo", LO, 32'd0);
`else
      issue(MD_MADDU, 32'd1, 32'd1);
      chk("madd_off_busy", {31'd0, busy}, 32'd0);
      chk("madd_off_hi", HI, 32'hA5A5_A5A5);
      chk("madd_off_lo", LO, 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
